// File: rtl/value_extractor.sv
// value_extractor: dequeue engine for the QuickQ sorted queue.
// Pops the head (minimum) entry at address 0, shifts the remaining entries
// down one slot, writes the empty sentinel into the vacated tail slot and
// publishes the decremented occupancy count.
module value_extractor #(
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 8,
  parameter int                DEPTH     = 5,
  parameter logic [DATA_W-1:0] EMPTY_VAL = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deq_req,
  input  logic              ins_busy,
  input  logic [CNT_W-1:0]  array_cnt_in,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [CNT_W-1:0]  bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [DATA_W-1:0] deq_data,
  output logic              deq_valid,
  output logic [CNT_W-1:0]  array_cnt_out,
  output logic              cnt_we,
  output logic              busy,
  output logic              empty,
  output logic              underflow
);

  typedef enum logic [2:0] {
    IDLE,
    RD_HEAD,
    CAP_HEAD,
    SHIFT_RD,
    SHIFT_WR,
    CLEAR,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  n_next;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_next;

  logic [CNT_W-1:0]  addr_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;
  logic [CNT_W-1:0]  cnt_out_d;
  logic              cnt_we_d;

  logic [DATA_W-1:0] wdata_q;
  logic              shift_wr_q;

  assign empty = (array_cnt_in == '0);

  // During SHIFT_WR the entry read in the previous cycle only arrives now,
  // so it is forwarded straight from the read port; otherwise the registered
  // write data (sentinel or zero) is driven.
  assign bram_wdata = shift_wr_q ? bram_rdata : wdata_q;

  // State, latched occupancy and shift index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n     <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      n     <= n_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic plus decode of the outputs belonging to the next state.
  always_comb begin
    state_next = state;
    n_next     = n;
    idx_next   = idx;
    addr_d     = '0;
    we_d       = 1'b0;
    wdata_d    = '0;
    cnt_out_d  = '0;
    cnt_we_d   = 1'b0;

    case (state)
      IDLE: begin
        if (deq_req && !ins_busy && (array_cnt_in != '0)) begin
          n_next     = (array_cnt_in > DEPTH_C) ? DEPTH_C : array_cnt_in;
          idx_next   = '0;
          state_next = RD_HEAD;
        end
      end
      RD_HEAD:  state_next = CAP_HEAD;
      CAP_HEAD: state_next = (n > ONE) ? SHIFT_RD : CLEAR;
      SHIFT_RD: state_next = SHIFT_WR;
      SHIFT_WR: begin
        idx_next   = idx + ONE;
        state_next = ((idx + ONE) < (n - ONE)) ? SHIFT_RD : CLEAR;
      end
      CLEAR:    state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    case (state_next)
      SHIFT_RD: addr_d = idx_next + ONE;
      SHIFT_WR: begin
        addr_d = idx_next;
        we_d   = 1'b1;
      end
      CLEAR: begin
        addr_d  = n_next - ONE;
        we_d    = 1'b1;
        wdata_d = EMPTY_VAL;
      end
      DONE: begin
        cnt_out_d = n_next - ONE;
        cnt_we_d  = 1'b1;
      end
      default: addr_d = '0;
    endcase
  end

  // Registered Moore outputs, head capture and underflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_addr     <= '0;
      bram_we       <= 1'b0;
      wdata_q       <= '0;
      shift_wr_q    <= 1'b0;
      deq_data      <= '0;
      deq_valid     <= 1'b0;
      array_cnt_out <= '0;
      cnt_we        <= 1'b0;
      busy          <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      bram_addr     <= addr_d;
      bram_we       <= we_d;
      wdata_q       <= wdata_d;
      shift_wr_q    <= (state_next == SHIFT_WR);
      deq_valid     <= (state == CAP_HEAD);
      if (state == CAP_HEAD) begin
        deq_data <= bram_rdata;
      end
      array_cnt_out <= cnt_out_d;
      cnt_we        <= cnt_we_d;
      busy          <= (state_next != IDLE);
      underflow     <= (state == IDLE) && deq_req && (array_cnt_in == '0);
    end
  end

endmodule

// File: tb/tb_value_extractor.sv
// tb_value_extractor: directed scenarios for the dequeue engine against a
// small synchronous-read BRAM model.
module tb_value_extractor;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam logic [31:0] EV = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              deq_req;
  logic              ins_busy;
  logic [CNT_W-1:0]  array_cnt_in;
  logic [DATA_W-1:0] bram_rdata;
  logic [CNT_W-1:0]  bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] deq_data;
  logic              deq_valid;
  logic [CNT_W-1:0]  array_cnt_out;
  logic              cnt_we;
  logic              busy;
  logic              empty;
  logic              underflow;

  logic [31:0] mem [0:7];
  logic [31:0] init_vals [0:4];
  logic        load_all = 1'b0;

  int checks   = 0;
  int failures = 0;

  value_extractor dut (
    .clk          (clk),
    .rst          (rst),
    .deq_req      (deq_req),
    .ins_busy     (ins_busy),
    .array_cnt_in (array_cnt_in),
    .bram_rdata   (bram_rdata),
    .bram_addr    (bram_addr),
    .bram_we      (bram_we),
    .bram_wdata   (bram_wdata),
    .deq_data     (deq_data),
    .deq_valid    (deq_valid),
    .array_cnt_out(array_cnt_out),
    .cnt_we       (cnt_we),
    .busy         (busy),
    .empty        (empty),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // BRAM model: synchronous write, read data one cycle after the address.
  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < 5; i++) mem[i] <= init_vals[i];
    end else if (bram_we) begin
      mem[bram_addr[2:0]] <= bram_wdata;
    end
    bram_rdata <= mem[bram_addr[2:0]];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, b, c, d, e);
    init_vals[0] = a;
    init_vals[1] = b;
    init_vals[2] = c;
    init_vals[3] = d;
    init_vals[4] = e;
    load_all = 1'b1;
    step;
    load_all = 1'b0;
  endtask

  task automatic test_reset;
    logic [127:0] outs;
    rst = 1'b1;
    deq_req = 1'b0;
    ins_busy = 1'b0;
    array_cnt_in = '0;
    step;
    step;
    rst = 1'b0;
    step;
    outs = {bram_addr, bram_we, bram_wdata, deq_data, deq_valid,
            array_cnt_out, cnt_we, busy, underflow};
    checks++;
    if (outs !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", outs);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_pop_three;
    logic [15:0] exp_busy;
    logic [15:0] exp_we;
    exp_busy = 16'b0000_0001_1111_1110;
    exp_we   = 16'b0000_0000_1101_0000;
    load(32'd2, 32'd5, 32'd9, EV, EV);
    array_cnt_in = 8'd3;
    checks++;
    if (empty !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pop3_empty got=%b exp=0", empty);
    end
    deq_req = 1'b1;
    step;
    deq_req = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      checks++;
      if (busy !== exp_busy[t]) begin
        failures++;
        $display("[TB] FAIL pop3_busy t=%0d got=%b exp=%b", t, busy, exp_busy[t]);
      end
      checks++;
      if (bram_we !== exp_we[t]) begin
        failures++;
        $display("[TB] FAIL pop3_we t=%0d got=%b exp=%b", t, bram_we, exp_we[t]);
      end
      checks++;
      if (deq_valid !== (t == 3)) begin
        failures++;
        $display("[TB] FAIL pop3_valid t=%0d got=%b", t, deq_valid);
      end
      checks++;
      if (cnt_we !== (t == 8)) begin
        failures++;
        $display("[TB] FAIL pop3_cnt_we t=%0d got=%b", t, cnt_we);
      end
      if (t == 3) begin
        checks++;
        if (deq_data !== 32'd2) begin
          failures++;
          $display("[TB] FAIL pop3_data got=%h exp=2", deq_data);
        end
      end
      if (t == 8) begin
        checks++;
        if (array_cnt_out !== 8'd2) begin
          failures++;
          $display("[TB] FAIL pop3_cnt_out got=%0d exp=2", array_cnt_out);
        end
      end
      step;
    end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !== {32'd5, 32'd9, EV, EV, EV}) begin
      failures++;
      $display("[TB] FAIL pop3_mem got=%h %h %h %h %h exp=5 9 ffffffff ffffffff ffffffff",
               mem[0], mem[1], mem[2], mem[3], mem[4]);
    end
  endtask

  task automatic test_single;
    load(32'hf657c062, EV, EV, EV, EV);
    array_cnt_in = 8'd1;
    deq_req = 1'b1;
    step;
    deq_req = 1'b0;
    step;
    step;
    checks++;
    if ({deq_valid, deq_data} !== {1'b1, 32'hf657c062}) begin
      failures++;
      $display("[TB] FAIL single_head got=%b/%h exp=1/f657c062", deq_valid, deq_data);
    end
    checks++;
    if ({bram_we, bram_addr, bram_wdata} !== {1'b1, 8'd0, EV}) begin
      failures++;
      $display("[TB] FAIL single_clear got=%b/%0d/%h exp=1/0/ffffffff",
               bram_we, bram_addr, bram_wdata);
    end
    step;
    checks++;
    if ({cnt_we, array_cnt_out, busy} !== {1'b1, 8'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL single_done got=%b/%0d/%b exp=1/0/1", cnt_we, array_cnt_out, busy);
    end
    step;
    checks++;
    if ({busy, cnt_we} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL single_idle got=%b%b exp=00", busy, cnt_we);
    end
    checks++;
    if (mem[0] !== EV) begin
      failures++;
      $display("[TB] FAIL single_mem got=%h exp=ffffffff", mem[0]);
    end
  endtask

  task automatic test_full;
    int we_seen;
    int cnt_we_seen;
    we_seen = 0;
    cnt_we_seen = 0;
    load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    array_cnt_in = 8'd5;
    deq_req = 1'b1;
    step;
    deq_req = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      if (t == 5) deq_req = 1'b1;
      if (t == 12) deq_req = 1'b0;
      if (bram_we) we_seen++;
      if (cnt_we) cnt_we_seen++;
      if (t == 3) begin
        checks++;
        if ({deq_valid, deq_data} !== {1'b1, 32'd1}) begin
          failures++;
          $display("[TB] FAIL full_head got=%b/%h exp=1/1", deq_valid, deq_data);
        end
      end
      if (t == 12) begin
        checks++;
        if ({cnt_we, array_cnt_out} !== {1'b1, 8'd4}) begin
          failures++;
          $display("[TB] FAIL full_done got=%b/%0d exp=1/4", cnt_we, array_cnt_out);
        end
      end
      if (t == 13 || t == 14) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL full_idle t=%0d got=%b exp=0", t, busy);
        end
      end
      step;
    end
    checks++;
    if (we_seen !== 5 || cnt_we_seen !== 1) begin
      failures++;
      $display("[TB] FAIL full_strobes got=we%0d/cnt%0d exp=we5/cnt1", we_seen, cnt_we_seen);
    end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !== {32'd2, 32'd3, 32'd4, 32'd5, EV}) begin
      failures++;
      $display("[TB] FAIL full_mem got=%h %h %h %h %h exp=2 3 4 5 ffffffff",
               mem[0], mem[1], mem[2], mem[3], mem[4]);
    end
  endtask

  task automatic test_underflow;
    array_cnt_in = 8'd0;
    deq_req = 1'b1;
    step;
    deq_req = 1'b0;
    checks++;
    if ({underflow, bram_we, busy} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL uflow_pulse got=%b%b%b exp=100", underflow, bram_we, busy);
    end
    step;
    checks++;
    if ({underflow, bram_we, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL uflow_end got=%b%b%b exp=000", underflow, bram_we, busy);
    end
    deq_req = 1'b1;
    step;
    step;
    deq_req = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uflow_held got=%b exp=1", underflow);
    end
    step;
  endtask

  task automatic test_ins_busy;
    load(32'd7, 32'd8, EV, EV, EV);
    array_cnt_in = 8'd2;
    ins_busy = 1'b1;
    deq_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step;
      checks++;
      if ({busy, bram_we} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL insb_blocked c=%0d got=%b%b exp=00", c, busy, bram_we);
      end
    end
    ins_busy = 1'b0;
    step;
    deq_req = 1'b0;
    checks++;
    if ({busy, bram_addr} !== {1'b1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL insb_start got=%b/%0d exp=1/0", busy, bram_addr);
    end
    step;
    step;
    checks++;
    if ({deq_valid, deq_data} !== {1'b1, 32'd7}) begin
      failures++;
      $display("[TB] FAIL insb_head got=%b/%h exp=1/7", deq_valid, deq_data);
    end
    step;
    step;
    step;
    checks++;
    if ({cnt_we, array_cnt_out} !== {1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL insb_done got=%b/%0d exp=1/1", cnt_we, array_cnt_out);
    end
    step;
    checks++;
    if ({busy, mem[0], mem[1]} !== {1'b0, 32'd8, EV}) begin
      failures++;
      $display("[TB] FAIL insb_end got=%b/%h/%h exp=0/8/ffffffff", busy, mem[0], mem[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] outs;
    int cnt_we_seen;
    cnt_we_seen = 0;
    load(32'd2, 32'd5, 32'd9, EV, EV);
    array_cnt_in = 8'd3;
    deq_req = 1'b1;
    step;
    deq_req = 1'b0;
    for (int t = 1; t < 5; t++) begin
      if (cnt_we) cnt_we_seen++;
      step;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    outs = {bram_addr, bram_we, bram_wdata, deq_data, deq_valid,
            array_cnt_out, cnt_we, busy, underflow};
    checks++;
    if (outs !== 128'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs got=%h exp=0", outs);
    end
    for (int t = 0; t < 6; t++) begin
      if (cnt_we || busy) cnt_we_seen++;
      step;
    end
    checks++;
    if (cnt_we_seen !== 0) begin
      failures++;
      $display("[TB] FAIL rstmid_quiet got=%0d exp=0", cnt_we_seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    deq_req = 1'b0;
    ins_busy = 1'b0;
    array_cnt_in = '0;
    test_reset;
    test_pop_three;
    test_single;
    test_full;
    test_underflow;
    test_ins_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/value_extractor.md
# value_extractor

Dequeue engine for the QuickQ BRAM-backed sorted queue; the removal side that complements the insertion/compare path (valueRouter). On a pop request it reads the head entry at address 0, which holds the minimum, and returns it to the requester. It then shifts every remaining entry down one slot, writes the empty sentinel into the vacated tail slot, and publishes the decremented occupancy count. It sits between the queue BRAM port and the consumer, sharing the count register with the insertion side.

## Interface
- DATA_W, 32, entry width
- CNT_W, 8, count/address width
- DEPTH, 5, queue capacity in entries
- EMPTY_VAL, 32'hFFFFFFFF, sentinel marking an unused slot
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- deq_req  in  1  pop request, sampled only in IDLE
- ins_busy  in  1  insertion side active; blocks pop start
- array_cnt_in  in  CNT_W  current occupancy
- bram_rdata  in  DATA_W  BRAM read data, valid 1 cycle after address
- bram_addr  out  CNT_W  BRAM address
- bram_we  out  1  BRAM write enable
- bram_wdata  out  DATA_W  BRAM write data
- deq_data  out  DATA_W  popped head value
- deq_valid  out  1  1-cycle pulse, deq_data valid
- array_cnt_out  out  CNT_W  new occupancy, valid while cnt_we=1
- cnt_we  out  1  1-cycle strobe, load array_cnt_out into count register
- busy  out  1  high whenever state != IDLE
- empty  out  1  combinational, (array_cnt_in == 0)
- underflow  out  1  1-cycle pulse, pop requested on an empty queue

## Operation
- States: IDLE, RD_HEAD, CAP_HEAD, SHIFT_RD, SHIFT_WR, CLEAR, DONE.
- IDLE handles deq_req as follows:
  - deq_req=1, ins_busy=0, array_cnt_in>0: latch n = min(array_cnt_in, DEPTH), set idx=0, go to RD_HEAD.
  - deq_req=1, array_cnt_in=0: underflow=1 next cycle; stay in IDLE; no BRAM access.
  - deq_req=1, ins_busy=1: stay in IDLE with no response. The requester holds deq_req until the pop starts.
- RD_HEAD: bram_addr=0, bram_we=0.
- CAP_HEAD: register deq_data=bram_rdata; deq_valid=1 in the following cycle. Go to SHIFT_RD if n>1, otherwise CLEAR.
- SHIFT_RD: bram_addr=idx+1, bram_we=0.
- SHIFT_WR: bram_addr=idx, bram_we=1, bram_wdata=bram_rdata; idx++. Go to SHIFT_RD if idx+1 < n-1 (pre-increment idx), otherwise CLEAR.
- CLEAR: bram_addr=n-1, bram_we=1, bram_wdata=EMPTY_VAL.
- DONE: array_cnt_out=n-1, cnt_we=1; go to IDLE.
- deq_req while busy=1 is ignored and not queued.
- Count arithmetic is unsigned CNT_W. n-1 never underflows because n≥1 is guaranteed on entry.
- Reset (any state, including mid-shift) behaves as follows:
  - State goes to IDLE and all outputs return to their reset values.
  - BRAM contents may be partially shifted and the count is not updated. The owner must reinitialise the queue.

## Timing
- Reset values: bram_addr=0, bram_we=0, bram_wdata=0, deq_data=0, deq_valid=0, array_cnt_out=0, cnt_we=0, busy=0, underflow=0.
- Outputs in each state are registered Moore outputs. The exception is empty, which is combinational.
- Pop accepted at cycle T0 with occupancy N:
  - busy=1 from T1.
  - RD_HEAD at T1, CAP_HEAD at T2, deq_valid at T3.
  - Shift pairs occupy T3..T(2N).
  - CLEAR at T(2N+1).
  - DONE/cnt_we at T(2N+2).
  - busy=0 and IDLE at T(2N+3).
  - Total occupancy: 2N+2 busy cycles.
- N=1: RD_HEAD T1, CAP_HEAD T2, CLEAR T3, DONE T4, IDLE T5.
- A new pop can be accepted at T(2N+3) at the earliest, using the updated array_cnt_in.
- Underflow: deq_req at T0 with empty=1 gives underflow=1 during T1 only. A held request re-pulses underflow every cycle.
- array_cnt_in > DEPTH saturates to DEPTH.

## Test plan
- Reset, then release with array_cnt_in=0 -> all outputs 0, empty=1, busy=0.
- Memory {2,5,9,FFFFFFFF,FFFFFFFF}, array_cnt_in=3, pop -> deq_data=2 with deq_valid at T3; memory becomes {5,9,FFFFFFFF,...}; cnt_we=1 with array_cnt_out=2 at T8; busy=0 at T9.
- array_cnt_in=1, memory[0]=32'hf657c062, pop -> deq_data=f657c062 at T3; memory[0]=FFFFFFFF written at T3; array_cnt_out=0 at T4.
- Full queue {1,2,3,4,5}, array_cnt_in=5, pop -> deq_data=1; memory {2,3,4,5,FFFFFFFF}; cnt_we at T12 with array_cnt_out=4. A second deq_req asserted at T5 is ignored.
- array_cnt_in=0, deq_req pulsed 1 cycle -> underflow=1 one cycle; bram_we stays 0.
- Additional edge scenarios:
  - ins_busy=1 held 3 cycles with deq_req=1 -> no BRAM activity; the pop starts the cycle after ins_busy falls.
  - rst asserted at T5 of a 3-entry pop -> IDLE next cycle, all outputs 0, cnt_we never pulsed.
